// File: rtl/xsleena_rom_loader.sv
// HPS ioctl download splitter: maps each accepted byte onto a region-relative write
// on the shared bram_* ROM-load bus, counting and checksumming the image as it goes.
module xsleena_rom_loader #(
  parameter int                 NREG        = 8,
  parameter logic [NREG*20-1:0] REGION_BASE = {20'h38000, 20'h30000, 20'h28000, 20'h20000,
                                               20'h18000, 20'h10000, 20'h08000, 20'h00000},
  parameter logic [19:0]        TOTAL_BYTES = 20'h40000,
  parameter logic [7:0]         ROM_INDEX   = 8'h00
) (
  input  logic            clk,
  input  logic            RESETn,
  input  logic            ioctl_download,
  input  logic [7:0]      ioctl_index,
  input  logic            ioctl_wr,
  input  logic [24:0]     ioctl_addr,
  input  logic [7:0]      ioctl_dout,
  output logic            ioctl_wait,
  output logic [19:0]     bram_addr,
  output logic [7:0]      bram_data,
  output logic            bram_wr,
  output logic [NREG-1:0] bram_cs,
  output logic            rom_ready,
  output logic            load_error,
  output logic [7:0]      checksum
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] DECODE = 3'd2;
  localparam logic [2:0] WRITE  = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  logic [2:0]      state;
  logic [24:0]     count;
  logic            overrun;
  logic            in_range;
  logic            image_ok;
  logic [NREG-1:0] cs_next;
  logic [19:0]     rel_next;

  assign in_range = ioctl_addr < {5'd0, TOTAL_BYTES};
  assign image_ok = (count == {5'd0, TOTAL_BYTES}) && !overrun;

  // Highest region whose base is <= addr wins; bases are ascending.
  always_comb begin
    cs_next    = '0;
    cs_next[0] = 1'b1;
    rel_next   = ioctl_addr[19:0] - REGION_BASE[19:0];
    for (int i = 1; i < NREG; i++) begin
      if (ioctl_addr >= {5'd0, REGION_BASE[i*20 +: 20]}) begin
        cs_next    = '0;
        cs_next[i] = 1'b1;
        rel_next   = ioctl_addr[19:0] - REGION_BASE[i*20 +: 20];
      end
    end
  end

  assign ioctl_wait = (state == DECODE) || (state == WRITE);
  assign bram_wr    = (state == WRITE);

  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      state      <= IDLE;
      count      <= '0;
      overrun    <= 1'b0;
      checksum   <= '0;
      rom_ready  <= 1'b0;
      load_error <= 1'b0;
      bram_addr  <= '0;
      bram_data  <= '0;
      bram_cs    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ioctl_download && ioctl_index == ROM_INDEX) begin
            state      <= LOAD;
            count      <= '0;
            overrun    <= 1'b0;
            checksum   <= '0;
            rom_ready  <= 1'b0;
            load_error <= 1'b0;
          end
        end
        LOAD: begin
          // Decoded bus fields are captured with the strobe so they are
          // stable for the whole DECODE/WRITE window.
          if (ioctl_wr && in_range) begin
            state     <= DECODE;
            bram_addr <= rel_next;
            bram_cs   <= cs_next;
            bram_data <= ioctl_dout;
          end else if (!ioctl_download) begin
            state <= DONE;
          end
        end
        DECODE: begin
          if (ioctl_wr) overrun <= 1'b1;
          state <= WRITE;
        end
        WRITE: begin
          if (ioctl_wr) overrun <= 1'b1;
          count    <= count + 25'd1;
          checksum <= checksum + bram_data;
          state    <= LOAD;
        end
        DONE: begin
          rom_ready  <= image_ok;
          load_error <= !image_ok;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xsleena_rom_loader.sv
// Randomized scoreboard bench for xsleena_rom_loader on a scaled-down image
// (8 regions of 256 bytes) so several complete downloads fit in a short run.
module tb_xsleena_rom_loader;
  localparam int NREG  = 8;
  localparam int RSZ   = 256;
  localparam int TOTAL = NREG * RSZ;
  localparam logic [NREG*20-1:0] BASES = {20'h700, 20'h600, 20'h500, 20'h400,
                                          20'h300, 20'h200, 20'h100, 20'h000};

  logic            clk = 1'b0;
  logic            RESETn;
  logic            ioctl_download;
  logic [7:0]      ioctl_index;
  logic            ioctl_wr;
  logic [24:0]     ioctl_addr;
  logic [7:0]      ioctl_dout;
  logic            ioctl_wait;
  logic [19:0]     bram_addr;
  logic [7:0]      bram_data;
  logic            bram_wr;
  logic [NREG-1:0] bram_cs;
  logic            rom_ready;
  logic            load_error;
  logic [7:0]      checksum;

  xsleena_rom_loader #(
    .NREG(NREG), .REGION_BASE(BASES), .TOTAL_BYTES(20'(TOTAL)), .ROM_INDEX(8'h00)
  ) dut (
    .clk(clk), .RESETn(RESETn), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait), .bram_addr(bram_addr), .bram_data(bram_data),
    .bram_wr(bram_wr), .bram_cs(bram_cs), .rom_ready(rom_ready),
    .load_error(load_error), .checksum(checksum)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NREG-1:0] cs;
    logic [19:0]     addr;
    logic [7:0]      data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  checks = 0;
  int  failures = 0;
  int  wr_count = 0;
  int  exp_sum = 0;
  int  wr_base;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: region = addr / size, offset = addr % size.
  function automatic wr_t model(input int a, input logic [7:0] d);
    wr_t w;
    w.cs         = '0;
    w.cs[a/RSZ]  = 1'b1;
    w.addr       = 20'(a % RSZ);
    w.data       = d;
    return w;
  endfunction

  always @(negedge clk) begin
    if (bram_wr === 1'b1) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_wr actual=addr %0h cs %0h required=no write", bram_addr, bram_cs);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_cs", 32'(bram_cs), 32'(mon_e.cs));
        check("wr_addr", 32'(bram_addr), 32'(mon_e.addr));
        check("wr_data", 32'(bram_data), 32'(mon_e.data));
      end
    end
  end

  task automatic send(input int a, input logic [7:0] d, input int gap);
    @(negedge clk);
    ioctl_addr = a[24:0]; ioctl_dout = d; ioctl_wr = 1'b1;
    if (a < TOTAL) begin exp_q.push_back(model(a, d)); exp_sum += d; end
    @(negedge clk);
    ioctl_wr = 1'b0;
    repeat (gap - 2) @(negedge clk);
  endtask

  // Strobe sampled at edge N; probes after N, N+1, N+2.
  task automatic send_timed(input int a, input logic [7:0] d);
    wr_t w;
    w = model(a, d);
    @(negedge clk);
    ioctl_addr = a[24:0]; ioctl_dout = d; ioctl_wr = 1'b1;
    exp_q.push_back(w); exp_sum += d;
    @(negedge clk);
    ioctl_wr = 1'b0;
    check("t1_wait", 32'(ioctl_wait), 1);
    check("t1_wr", 32'(bram_wr), 0);
    check("t1_cs", 32'(bram_cs), 32'(w.cs));
    check("t1_addr", 32'(bram_addr), 32'(w.addr));
    @(negedge clk);
    check("t2_wait", 32'(ioctl_wait), 1);
    check("t2_wr", 32'(bram_wr), 1);
    @(negedge clk);
    check("t3_wait", 32'(ioctl_wait), 0);
    check("t3_wr", 32'(bram_wr), 0);
  endtask

  task automatic send_overrun(input int a, input logic [7:0] d, input logic [7:0] d2);
    @(negedge clk);
    ioctl_addr = a[24:0]; ioctl_dout = d; ioctl_wr = 1'b1;
    exp_q.push_back(model(a, d)); exp_sum += d;
    @(negedge clk);
    ioctl_dout = d2;
    @(negedge clk);
    ioctl_wr = 1'b0;
    @(negedge clk);
  endtask

  task automatic start_dl(input logic [7:0] idx);
    @(negedge clk);
    ioctl_index = idx; ioctl_download = 1'b1;
    @(negedge clk);
  endtask

  task automatic end_dl();
    @(negedge clk);
    ioctl_download = 1'b0;
    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 0);
  endtask

  task automatic load_range(input int n, input bit timed, input int ovr_at);
    for (int a = 0; a < n; a++) begin
      if (timed && a == RSZ - 1)      send_timed(a, 8'hA5);
      else if (timed && a == RSZ)     send_timed(a, 8'h5A);
      else if (a == ovr_at)           send_overrun(a, 8'($urandom), 8'($urandom));
      else                            send(a, 8'($urandom), int'($urandom_range(3, 4)));
    end
  endtask

  task automatic check_end(input string tag, input logic ready, input int writes);
    check({tag, "_ready"}, 32'(rom_ready), 32'(ready));
    check({tag, "_error"}, 32'(load_error), 32'(!ready));
    check({tag, "_checksum"}, 32'(checksum), 32'(exp_sum[7:0]));
    check({tag, "_writes"}, 32'(wr_count - wr_base), 32'(writes));
  endtask

  initial begin
    logic wait_seen;
    RESETn = 1'b0; ioctl_download = 1'b0; ioctl_index = 8'h00;
    ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0;
    repeat (3) @(negedge clk);
    check("rst_outputs", {bram_addr, bram_data, bram_wr, ioctl_wait}, 0);
    check("rst_flags", {bram_cs, rom_ready, load_error, checksum}, 0);
    RESETn = 1'b1;

    // Full image with region-boundary timing probes and an out-of-range byte.
    exp_sum = 0; wr_base = wr_count;
    start_dl(8'h00);
    load_range(TOTAL, 1'b1, -1);
    send(TOTAL + 5, 8'h77, 3);
    end_dl();
    check_end("full", 1'b1, TOTAL);

    // Foreign index is ignored; previous result retained.
    wr_base = wr_count; wait_seen = 1'b0;
    start_dl(8'h01);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      ioctl_addr = 25'(k); ioctl_dout = 8'(k); ioctl_wr = 1'b1;
      @(negedge clk); ioctl_wr = 1'b0; wait_seen |= ioctl_wait;
      @(negedge clk); wait_seen |= ioctl_wait;
      @(negedge clk); wait_seen |= ioctl_wait;
    end
    @(negedge clk); ioctl_download = 1'b0; ioctl_index = 8'h00;
    repeat (3) @(negedge clk);
    check("foreign_wait", 32'(wait_seen), 0);
    check_end("foreign", 1'b1, 0);

    // Short image.
    exp_sum = 0; wr_base = wr_count;
    start_dl(8'h00);
    load_range(TOTAL - 1, 1'b0, -1);
    end_dl();
    check_end("short", 1'b0, TOTAL - 1);

    // Overrun inside an otherwise complete image.
    exp_sum = 0; wr_base = wr_count;
    start_dl(8'h00);
    load_range(TOTAL, 1'b0, 37);
    end_dl();
    check_end("overrun", 1'b0, TOTAL);

    // Asynchronous reset mid-download.
    exp_sum = 0;
    start_dl(8'h00);
    load_range(100, 1'b0, -1);
    @(negedge clk);
    #2 RESETn = 1'b0;
    #1;
    check("arst_outputs", {bram_addr, bram_data, bram_wr, ioctl_wait}, 0);
    check("arst_flags", {bram_cs, rom_ready, load_error, checksum}, 0);
    ioctl_download = 1'b0;
    @(negedge clk);
    RESETn = 1'b1;
    exp_q.delete();

    // Clean reload after reset.
    exp_sum = 0; wr_base = wr_count;
    start_dl(8'h00);
    load_range(TOTAL, 1'b0, -1);
    end_dl();
    check_end("reload", 1'b1, TOTAL);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
